ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17, meaning RAM byte-address width (128 KiB).
REQ-002 Parameter FIFO_DEPTH, default 8, meaning entries per UART FIFO (power of two, >=4).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global enable for the memory-side port.
REQ-006 write_or_read  input  1  1 = write, 0 = read (from memory controller).
REQ-007 addr_from_ctrl  input  32  byte address from memory controller.
REQ-008 data_from_ctrl  input  8  write byte from memory controller.
REQ-009 data_to_ctrl  output  8  registered read byte to memory controller.
REQ-010 uart_full  output  1  TX FIFO nearly full; controller must hold stores.
REQ-011 tx_valid  output  1  TX byte available to UART transmitter.
REQ-012 tx_data  output  8  TX byte (head of TX FIFO).
REQ-013 tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-014 rx_valid  input  1  UART receiver presents a byte this cycle.
REQ-015 rx_data  input  8  received byte.

Function
REQ-016 Decode: addr_from_ctrl[17]=0 selects RAM at addr_from_ctrl[RAM_AW-1:0]; addr_from_ctrl[17]=1 selects IO at addr_from_ctrl[2:0].
REQ-017 All memory-side accesses occur only on edges with rdy=1; with rdy=0, RAM, data_to_ctrl and RX pops are frozen.
REQ-018 RAM write: write_or_read=1, RAM selected -> mem[addr] <= data_from_ctrl on that edge.
REQ-019 RAM read: write_or_read=0, RAM selected -> data_to_ctrl = mem[addr] after exactly one edge (1-cycle latency, one byte per cycle, back-to-back addresses allowed).
REQ-020 Read-after-write to same address on consecutive cycles returns the newly written byte.
REQ-021 IO write to offset 0 pushes data_from_ctrl into TX FIFO; if TX FIFO full, byte dropped, FIFO unchanged.
REQ-022 IO writes to other offsets are ignored.
REQ-023 IO read offset 0 pops RX FIFO head into data_to_ctrl next cycle; RX empty -> 8'h00, no pop.
REQ-024 IO read offset 4 -> data_to_ctrl = {7'b0, rx_nonempty} next cycle, no pop.
REQ-025 IO read other offsets -> 8'h00.
REQ-026 Address 0 with write_or_read=0 (controller idle) is a harmless RAM read; no side effects.
REQ-027 tx_valid = TX FIFO nonempty; tx_data = TX head; pop on tx_valid && tx_ready; independent of rdy.
REQ-028 rx_valid pushes rx_data into RX FIFO; if RX full, byte dropped; independent of rdy.
REQ-029 uart_full = (TX count >= FIFO_DEPTH-1), derived from registered count (no dependence on same-cycle inputs).
REQ-030 Simultaneous push and pop on one FIFO: count unchanged, both operations performed; when full, simultaneous push+pop is accepted.
REQ-031 Pointers wrap modulo FIFO_DEPTH; count width holds 0..FIFO_DEPTH.

Reset
REQ-032 rst_n low asynchronously clears data_to_ctrl to 8'h00, all FIFO pointers and counts to 0, tx_valid to 0, uart_full to 0.
REQ-033 RAM contents are not reset; reset mid-access aborts it with no RAM write on that edge.
REQ-034 FIFO contents are discarded on reset; first push after release lands at entry 0.

Verification
REQ-035 Write 8'hA5 to 0x00010, then read 0x00010 -> data_to_ctrl = 8'hA5 one cycle after read address.
REQ-036 Stream reads of 0x0..0x3 preloaded 11,22,33,44 -> data_to_ctrl 11,22,33,44 on four consecutive cycles, each one cycle late.
REQ-037 tx_ready=0, write 8 bytes to 0x30000 -> uart_full=1 after 7th push, 8th stored, 9th dropped; then tx_ready=1 -> 8 bytes emitted in order.
REQ-038 rx_valid with 8'h41 -> read 0x30004 returns 8'h01; read 0x30000 returns 8'h41; read 0x30000 again returns 8'h00.
REQ-039 rdy=0 during RAM write to 0x00020 -> mem unchanged; tx drain continues during rdy=0.
REQ-040 Assert rst_n low mid-stream with TX 3 entries -> tx_valid, uart_full, data_to_ctrl 0 immediately; RAM data written earlier still readable.

Source files
------------

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_io_responder
//  Brief    : Byte RAM plus memory-mapped UART TX/RX FIFOs behind a single
//             memory-controller port with 1-cycle registered read data.
//  Revision : 1.0
// ============================================================================

module ram_io_responder_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_depth) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
endmodule

module ram_io_responder #(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        write_or_read,
    input  logic [31:0] addr_from_ctrl,
    input  logic [7:0]  data_from_ctrl,
    output logic [7:0]  data_to_ctrl,
    output logic        uart_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);
    localparam int            CW            = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] c_full_thresh = CW'(FIFO_DEPTH - 1);
    localparam logic [2:0]    c_off_data    = 3'd0;
    localparam logic [2:0]    c_off_status  = 3'd4;

    logic [7:0]        r_ram [0:(1 << RAM_AW) - 1];
    logic [7:0]        r_data_to_ctrl;
    logic              w_io_sel;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [2:0]        w_io_off;
    logic              w_ram_we;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_rx_pop;
    logic              w_rx_nonempty;
    logic [7:0]        w_rx_head;
    logic [CW-1:0]     w_tx_count;
    logic [CW-1:0]     w_rx_count;
    logic [7:0]        w_rd_data;
    logic              w_unused_addr;

    assign w_io_sel      = addr_from_ctrl[17];
    assign w_ram_addr    = addr_from_ctrl[RAM_AW-1:0];
    assign w_io_off      = addr_from_ctrl[2:0];
    assign w_unused_addr = ^addr_from_ctrl;

    assign w_ram_we  = rdy && !w_io_sel && write_or_read;
    assign w_tx_push = rdy && w_io_sel && write_or_read && (w_io_off == c_off_data);
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_rx_nonempty = (w_rx_count != '0);
    assign w_rx_pop  = rdy && w_io_sel && !write_or_read
                       && (w_io_off == c_off_data) && w_rx_nonempty;

    ram_io_responder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_tx_push),
        .push_data (data_from_ctrl),
        .pop       (w_tx_pop),
        .head      (tx_data),
        .count     (w_tx_count)
    );

    ram_io_responder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .head      (w_rx_head),
        .count     (w_rx_count)
    );

    assign tx_valid  = (w_tx_count != '0);
    assign uart_full = (w_tx_count >= c_full_thresh);

    // RAM has no reset; gating on rst_n keeps an access cut short by reset
    // from landing in memory.
    always_ff @(posedge clk) begin
        if (w_ram_we && rst_n) begin
            r_ram[w_ram_addr] <= data_from_ctrl;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_io_sel) begin
            w_rd_data = r_ram[w_ram_addr];
        end else begin
            case (w_io_off)
                c_off_data:   w_rd_data = w_rx_nonempty ? w_rx_head : 8'h00;
                c_off_status: w_rd_data = {7'b0, w_rx_nonempty};
                default:      w_rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_to_ctrl <= 8'h00;
        end else if (rdy && !write_or_read) begin
            r_data_to_ctrl <= w_rd_data;
        end
    end

    assign data_to_ctrl = r_data_to_ctrl;
endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_io_responder
//  Brief    : Scoreboard bench for ram_io_responder RAM, TX and RX paths.
//  Revision : 1.0
// ============================================================================
module tb_ram_io_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        write_or_read;
    logic [31:0] addr_from_ctrl;
    logic [7:0]  data_from_ctrl;
    logic [7:0]  data_to_ctrl;
    logic        uart_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    ram_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .write_or_read  (write_or_read),
        .addr_from_ctrl (addr_from_ctrl),
        .data_from_ctrl (data_from_ctrl),
        .data_to_ctrl   (data_to_ctrl),
        .uart_full      (uart_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data)
    );

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        write_or_read  = wr;
        addr_from_ctrl = a;
        data_from_ctrl = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        drive(1'b1, a, d);
        tick();
        drive(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        drive(1'b0, 32'h0, 8'h00);
        tick(); tick();
        exp = 8'h00;
        n_cmp++;
        if (data_to_ctrl !== exp) begin n_err++; $display("FAIL reset_data: got %h exp %h", data_to_ctrl, exp); end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
        n_cmp++;
        if (uart_full !== 1'b0) begin n_err++; $display("FAIL reset_uart_full: got %b exp 0", uart_full); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ram_rw();
        logic [7:0] exp;
        drive(1'b1, 32'h10, 8'hA5);
        tick();
        drive(1'b0, 32'h10, 8'h00);
        rd_q.push_back(8'hA5);
        tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (data_to_ctrl !== exp) begin n_err++; $display("FAIL raw_0x10: got %h exp %h", data_to_ctrl, exp); end
        bus_write(32'h1FFFF, 8'h5A);
        drive(1'b0, 32'h1FFFF, 8'h00);
        rd_q.push_back(8'h5A);
        tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (data_to_ctrl !== exp) begin n_err++; $display("FAIL ram_top: got %h exp %h", data_to_ctrl, exp); end
    endtask

    task automatic test_stream();
        logic [7:0] vals [4];
        logic [7:0] exp;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) bus_write(32'(i), vals[i]);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'(i), 8'h00);
            rd_q.push_back(vals[i]);
            tick();
            exp = rd_q.pop_front();
            n_cmp++;
            if (data_to_ctrl !== exp) begin n_err++; $display("FAIL stream_%0d: got %h exp %h", i, data_to_ctrl, exp); end
        end
        drive(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_tx_fifo();
        logic exp_full;
        logic [7:0] exp;
        tx_ready = 1'b0;
        bus_write(32'h30001, 8'hEE);
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL io_wr_off1: tx_valid got %b exp 0", tx_valid); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h30000, 8'(8'hC0 + i));
            if (i < 8) tx_q.push_back(8'(8'hC0 + i));
            tick();
            exp_full = ((i < 8 ? i + 1 : 8) >= 7);
            n_cmp++;
            if (uart_full !== exp_full) begin n_err++; $display("FAIL uart_full_push%0d: got %b exp %b", i + 1, uart_full, exp_full); end
        end
        // full FIFO: push and pop on the same edge are both accepted
        drive(1'b1, 32'h30000, 8'hCA);
        tx_ready = 1'b1;
        exp = tx_q.pop_front();
        n_cmp++;
        if (tx_data !== exp) begin n_err++; $display("FAIL tx_full_head: got %h exp %h", tx_data, exp); end
        tx_q.push_back(8'hCA);
        tick();
        tx_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        n_cmp++;
        if (uart_full !== 1'b1) begin n_err++; $display("FAIL uart_full_pushpop: got %b exp 1", uart_full); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = tx_q.pop_front();
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_err++; $display("FAIL tx_drain_%0d: got v=%b %h exp v=1 %h", i, tx_valid, tx_data, exp);
            end
            tick();
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0 || uart_full !== 1'b0) begin
            n_err++; $display("FAIL tx_empty: got v=%b full=%b exp 0 0", tx_valid, uart_full);
        end
    endtask

    task automatic test_rx();
        logic [31:0] addrs [5];
        logic [7:0]  exps  [5];
        logic [7:0]  exp;
        addrs = '{32'h30004, 32'h30000, 32'h30000, 32'h30004, 32'h30007};
        exps  = '{8'h01, 8'h41, 8'h00, 8'h00, 8'h00};
        rx_valid = 1'b1; rx_data = 8'h41;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, addrs[i], 8'h00);
            rd_q.push_back(exps[i]);
            tick();
            exp = rd_q.pop_front();
            n_cmp++;
            if (data_to_ctrl !== exp) begin n_err++; $display("FAIL rx_rd_%0d: got %h exp %h", i, data_to_ctrl, exp); end
        end
        drive(1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h50 + i);
            tick();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 32'h30000, 8'h00);
            rd_q.push_back(i < 8 ? 8'(8'h50 + i) : 8'h00);
            tick();
            exp = rd_q.pop_front();
            n_cmp++;
            if (data_to_ctrl !== exp) begin n_err++; $display("FAIL rx_full_%0d: got %h exp %h", i, data_to_ctrl, exp); end
        end
        drive(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_rdy_low();
        logic [7:0] exp;
        bus_write(32'h20, 8'h77);
        tx_ready = 1'b0;
        bus_write(32'h30000, 8'h61); tx_q.push_back(8'h61);
        bus_write(32'h30000, 8'h62); tx_q.push_back(8'h62);
        tick();
        n_cmp++;
        if (data_to_ctrl !== 8'h11) begin n_err++; $display("FAIL idle_read0: got %h exp 11", data_to_ctrl); end
        rdy = 1'b0; tx_ready = 1'b1;
        drive(1'b1, 32'h20, 8'h99);
        for (int i = 0; i < 2; i++) begin
            exp = tx_q.pop_front();
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_err++; $display("FAIL rdy0_tx_%0d: got v=%b %h exp v=1 %h", i, tx_valid, tx_data, exp);
            end
            tick();
        end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rdy0_tx_empty: got %b exp 0", tx_valid); end
        drive(1'b0, 32'h10, 8'h00);
        tick();
        n_cmp++;
        if (data_to_ctrl !== 8'h11) begin n_err++; $display("FAIL rdy0_frozen: got %h exp 11", data_to_ctrl); end
        rdy = 1'b1; tx_ready = 1'b0;
        drive(1'b0, 32'h20, 8'h00);
        rd_q.push_back(8'h77);
        tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (data_to_ctrl !== exp) begin n_err++; $display("FAIL rdy0_ram: got %h exp %h", data_to_ctrl, exp); end
        drive(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(32'h30000, 8'(8'h71 + i));
        drive(1'b0, 32'h10, 8'h00);
        tick();
        n_cmp++;
        if (data_to_ctrl !== 8'hA5) begin n_err++; $display("FAIL pre_reset_rd: got %h exp a5", data_to_ctrl); end
        drive(1'b1, 32'h10, 8'hEE);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_to_ctrl !== 8'h00 || tx_valid !== 1'b0 || uart_full !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got d=%h v=%b full=%b exp 00 0 0", data_to_ctrl, tx_valid, uart_full);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 32'h10, 8'h00);
        rd_q.push_back(8'hA5);
        tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (data_to_ctrl !== exp) begin n_err++; $display("FAIL ram_kept: got %h exp %h", data_to_ctrl, exp); end
        bus_write(32'h30000, 8'h3C);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
            n_err++; $display("FAIL tx_after_reset: got v=%b %h exp v=1 3c", tx_valid, tx_data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram_rw();
        test_stream();
        test_tx_fifo();
        test_rx();
        test_rdy_low();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
